// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the CPU/DMA requesters, the shared data memory
// and mem_port_arbiter.
//   master : requester + memory side (drives req/we/addr/wdata, mem_rdata)
//   slave  : arbiter side (drives gnt/rvalid/rdata, mem strobes, busy)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_addr, mem_wdata, mem_rd, mem_wr, busy
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_addr, mem_wdata, mem_rd, mem_wr, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data memory between the CPU control FSM and a DMA
// requester. CPU has fixed priority; after MAX_WAIT consecutive lost
// arbitrations the DMA wins. One transaction in flight at a time; reads wait
// MEM_LAT cycles and return data with a one-cycle rvalid pulse.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : mem_port_arbiter_if.slave (requester handshakes + memory port)
module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    state_t            state;
    state_t            state_next;
    owner_t            owner;
    logic [2:0]        lat_cnt;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;

    logic              cpu_win;
    logic              dma_win;
    logic              win;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              dma_starved;

    assign dma_starved = (wait_cnt == 4'(MAX_WAIT));

    // Arbitration and next state. Grants are gated by reset so nothing is
    // issued to memory while reset is held.
    always_comb begin
        state_next = state;
        cpu_win    = 1'b0;
        dma_win    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!reset) begin
                    if (bus.cpu_req && !(bus.dma_req && dma_starved))
                        cpu_win = 1'b1;
                    else if (bus.dma_req)
                        dma_win = 1'b1;
                end
                if ((cpu_win || dma_win) && !(dma_win ? bus.dma_we : bus.cpu_we))
                    state_next = S_WAIT;
            end
            S_WAIT: begin
                if (lat_cnt == 3'd1)
                    state_next = S_RESP;
            end
            S_RESP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        win       = cpu_win | dma_win;
        win_we    = dma_win ? bus.dma_we    : bus.cpu_we;
        win_addr  = dma_win ? bus.dma_addr  : bus.cpu_addr;
        win_wdata = dma_win ? bus.dma_wdata : bus.cpu_wdata;
    end

    assign bus.cpu_gnt    = cpu_win;
    assign bus.dma_gnt    = dma_win;
    assign bus.mem_rd     = win & ~win_we;
    assign bus.mem_wr     = win & win_we;
    // Address/data follow the winner in the grant cycle, otherwise hold the
    // last issued values (keeps the read address stable during S_WAIT).
    assign bus.mem_addr   = win ? win_addr  : addr_q;
    assign bus.mem_wdata  = win ? win_wdata : wdata_q;
    assign bus.cpu_rvalid = (state == S_RESP) && (owner == OWN_CPU);
    assign bus.dma_rvalid = (state == S_RESP) && (owner == OWN_DMA);
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.dma_rdata  = dma_rdata_q;
    assign bus.busy       = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner       <= OWN_CPU;
            lat_cnt     <= '0;
            wait_cnt    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            if (win) begin
                addr_q  <= win_addr;
                wdata_q <= win_wdata;
            end

            if (win && !win_we) begin
                lat_cnt <= 3'(MEM_LAT);
                owner   <= dma_win ? OWN_DMA : OWN_CPU;
            end else if (state == S_WAIT) begin
                lat_cnt <= lat_cnt - 3'd1;
            end

            if (state == S_WAIT && lat_cnt == 3'd1) begin
                if (owner == OWN_DMA)
                    dma_rdata_q <= bus.mem_rdata;
                else
                    cpu_rdata_q <= bus.mem_rdata;
            end

            // Only idle cycles count as lost arbitrations; pending cycles in
            // S_WAIT/S_RESP leave the count untouched.
            if (!bus.dma_req || dma_win)
                wait_cnt <= '0;
            else if (state == S_IDLE && !dma_starved)
                wait_cnt <= wait_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a MEM_LAT=1 instance checked every cycle against
// a transaction-level model, plus a MEM_LAT=3 instance checked with directed
// literal expectations.
module tb_mem_port_arbiter;

    localparam int AW     = 16;
    localparam int DW     = 16;
    localparam int LAT_A  = 1;
    localparam int MAXW_A = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_A), .MAX_WAIT(MAXW_A))
        dut_a (.clk(clk), .reset(reset), .bus(a.slave));
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .MAX_WAIT(4))
        dut_b (.clk(clk), .reset(reset), .bus(b.slave));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] init_val(input logic [15:0] addr);
        case (addr)
            16'h0010: init_val = 16'hBEEF;
            16'h00FF: init_val = 16'hA5A5;
            default:  init_val = {addr[7:0], ~addr[7:0]};
        endcase
    endfunction

    // Memory device for instance A: one-cycle synchronous read.
    logic [15:0] dev_a_data  [256];
    logic        dev_a_valid [256] = '{default: 1'b0};
    logic [15:0] pipe_a = '0;

    function automatic logic [15:0] dev_a_read(input logic [15:0] addr);
        dev_a_read = dev_a_valid[addr[7:0]] ? dev_a_data[addr[7:0]] : init_val(addr);
    endfunction

    always @(posedge clk) begin
        if (a.mem_wr) begin
            dev_a_data[a.mem_addr[7:0]]  <= a.mem_wdata;
            dev_a_valid[a.mem_addr[7:0]] <= 1'b1;
        end
        if (a.mem_rd)
            pipe_a <= dev_a_read(a.mem_addr);
    end
    assign a.mem_rdata = pipe_a;

    // Memory device for instance B: read-only, three-cycle pipeline.
    logic [15:0] pipe_b0 = '0, pipe_b1 = '0, pipe_b2 = '0;
    always @(posedge clk) begin
        pipe_b0 <= b.mem_rd ? init_val(b.mem_addr) : 16'h0000;
        pipe_b1 <= pipe_b0;
        pipe_b2 <= pipe_b1;
    end
    assign b.mem_rdata = pipe_b2;

    // Transaction-level model for instance A. m_rem counts cycles left before
    // the port is free again; a read occupies MEM_LAT+1 cycles after its grant
    // and its response appears in the last of them.
    logic [15:0] mm_data  [256];
    bit          mm_valid [256];
    int          m_rem, m_wait;
    bit          m_owner_dma;
    logic [15:0] m_pend, m_cpu_rdata, m_dma_rdata, m_addr, m_wdata;

    initial begin : compare
        bit idle, cw, dw, rvc, rvd, we;
        logic [15:0] waddr, wdat;
        for (int i = 0; i < 256; i++) mm_valid[i] = 1'b0;
        m_rem = 0; m_wait = 0; m_owner_dma = 1'b0;
        m_pend = '0; m_cpu_rdata = '0; m_dma_rdata = '0; m_addr = '0; m_wdata = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_rem = 0; m_wait = 0; m_cpu_rdata = '0; m_dma_rdata = '0;
                m_addr = '0; m_wdata = '0;
                check("model_reset_flags",
                      {a.cpu_gnt, a.dma_gnt, a.cpu_rvalid, a.dma_rvalid, a.busy, a.mem_rd, a.mem_wr}, 7'b0);
                check("model_reset_data", {a.mem_addr, a.mem_wdata, a.cpu_rdata, a.dma_rdata}, 64'h0);
            end else begin
                idle = (m_rem == 0);
                cw   = idle && a.cpu_req && !(a.dma_req && m_wait == MAXW_A);
                dw   = idle && a.dma_req && !cw;
                rvc  = (m_rem == 1) && !m_owner_dma;
                rvd  = (m_rem == 1) && m_owner_dma;
                if (rvc) m_cpu_rdata = m_pend;
                if (rvd) m_dma_rdata = m_pend;
                we = 1'b0;
                if (cw || dw) begin
                    we    = dw ? a.dma_we    : a.cpu_we;
                    waddr = dw ? a.dma_addr  : a.cpu_addr;
                    wdat  = dw ? a.dma_wdata : a.cpu_wdata;
                    m_addr  = waddr;
                    m_wdata = wdat;
                    if (we) begin
                        mm_data[waddr[7:0]]  = wdat;
                        mm_valid[waddr[7:0]] = 1'b1;
                    end else begin
                        m_pend = mm_valid[waddr[7:0]] ? mm_data[waddr[7:0]] : init_val(waddr);
                        m_owner_dma = dw;
                    end
                end
                check("model_flags",
                      {a.cpu_gnt, a.dma_gnt, a.cpu_rvalid, a.dma_rvalid, a.busy, a.mem_rd, a.mem_wr},
                      {cw, dw, rvc, rvd, !idle, (cw || dw) && !we, (cw || dw) && we});
                check("model_mem_bus", {a.mem_addr, a.mem_wdata}, {m_addr, m_wdata});
                check("model_rdata", {a.cpu_rdata, a.dma_rdata}, {m_cpu_rdata, m_dma_rdata});
                if (m_rem > 0) m_rem--;
                if ((cw || dw) && !we) m_rem = LAT_A + 1;
                if (!a.dma_req || dw) m_wait = 0;
                else if (idle && m_wait < MAXW_A) m_wait++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int first, n_cv, n_dv;
        a.cpu_req = 0; a.cpu_we = 0; a.cpu_addr = '0; a.cpu_wdata = '0;
        a.dma_req = 0; a.dma_we = 0; a.dma_addr = '0; a.dma_wdata = '0;
        b.cpu_req = 0; b.cpu_we = 0; b.cpu_addr = '0; b.cpu_wdata = '0;
        b.dma_req = 0; b.dma_we = 0; b.dma_addr = '0; b.dma_wdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_flags",
              {a.cpu_gnt, a.dma_gnt, a.cpu_rvalid, a.dma_rvalid, a.busy, a.mem_rd, a.mem_wr}, 7'b0);
        check("reset_rdata", {a.cpu_rdata, a.dma_rdata}, 32'h0);
        tick(); reset = 1'b0;

        // CPU read of 0x0010, one-cycle memory
        a.cpu_req = 1; a.cpu_we = 0; a.cpu_addr = 16'h0010;
        @(negedge clk);
        check("t1_gnt", {a.cpu_gnt, a.mem_rd, a.dma_gnt}, 3'b110);
        tick(); a.cpu_req = 0;
        @(negedge clk);
        check("t1_wait", {a.cpu_rvalid, a.busy}, 2'b01);
        tick();
        @(negedge clk);
        check("t1_rvalid", {a.cpu_rvalid, a.dma_rvalid}, 2'b10);
        check("t1_rdata", a.cpu_rdata, 16'hBEEF);
        tick();

        // Simultaneous writes: CPU first, DMA next cycle
        a.cpu_req = 1; a.cpu_we = 1; a.cpu_addr = 16'h0020; a.cpu_wdata = 16'h1234;
        a.dma_req = 1; a.dma_we = 1; a.dma_addr = 16'h0030; a.dma_wdata = 16'h5678;
        @(negedge clk);
        check("t2_c0", {a.cpu_gnt, a.dma_gnt, a.mem_wr}, 3'b101);
        check("t2_c0_addr", a.mem_addr, 16'h0020);
        tick(); a.cpu_req = 0;
        @(negedge clk);
        check("t2_c1", {a.cpu_gnt, a.dma_gnt, a.mem_wr}, 3'b011);
        tick(); a.dma_req = 0;
        @(negedge clk);
        check("t2_mem20", dev_a_read(16'h0020), 16'h1234);
        check("t2_mem30", dev_a_read(16'h0030), 16'h5678);
        tick();

        // Starvation override: DMA wins on the fifth idle cycle
        a.cpu_req = 1; a.cpu_we = 1; a.cpu_addr = 16'h0040; a.cpu_wdata = 16'h1111;
        a.dma_req = 1; a.dma_we = 1; a.dma_addr = 16'h0050; a.dma_wdata = 16'h2222;
        first = -1;
        for (int k = 0; k < 10 && first < 0; k++) begin
            @(negedge clk);
            if (a.dma_gnt) first = k;
            tick();
        end
        a.dma_req = 0;
        check("t3_dma_gnt_cycle", first, 4);
        @(negedge clk);
        check("t3_cpu_resume", {a.cpu_gnt, a.dma_gnt}, 2'b10);
        tick(); a.cpu_req = 0;

        // DMA read in flight holds off a later CPU request
        a.dma_req = 1; a.dma_we = 0; a.dma_addr = 16'h0060;
        @(negedge clk);
        check("t4_dma_gnt", {a.dma_gnt, a.cpu_gnt, a.mem_rd}, 3'b101);
        tick();
        a.dma_req = 0; a.cpu_req = 1; a.cpu_we = 0; a.cpu_addr = 16'h0070;
        first = -1; n_cv = 0; n_dv = 0;
        for (int k = 1; k < 12 && first < 0; k++) begin
            @(negedge clk);
            n_dv += a.dma_rvalid;
            n_cv += a.cpu_rvalid;
            if (a.cpu_gnt) first = k;
            tick();
        end
        a.cpu_req = 0;
        check("t4_cpu_gnt_cycle", first, 3);
        check("t4_dma_rvalid_count", n_dv, 1);
        check("t4_cpu_rvalid_count", n_cv, 0);
        check("t4_dma_rdata", a.dma_rdata, 16'h609F);
        check("t4_cpu_rdata_held", a.cpu_rdata, 16'hBEEF);
        repeat (3) tick();

        // Reset in the middle of a CPU read
        a.cpu_req = 1; a.cpu_we = 0; a.cpu_addr = 16'h0080;
        @(negedge clk);
        check("t5_gnt", a.cpu_gnt, 1'b1);
        tick(); a.cpu_req = 0; reset = 1'b1;
        @(negedge clk);
        check("t5_reset_flags",
              {a.cpu_gnt, a.dma_gnt, a.cpu_rvalid, a.dma_rvalid, a.busy, a.mem_rd, a.mem_wr}, 7'b0);
        tick(); reset = 1'b0;
        a.dma_req = 1; a.dma_we = 1; a.dma_addr = 16'h0090; a.dma_wdata = 16'h9999;
        @(negedge clk);
        check("t5_first_idle_gnt", {a.dma_gnt, a.mem_wr, a.busy}, 3'b110);
        tick(); a.dma_req = 0;
        n_cv = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cv += a.cpu_rvalid;
            tick();
        end
        check("t5_no_rvalid", n_cv, 0);
        check("t5_cpu_rdata", a.cpu_rdata, 16'h0000);

        // Three-cycle memory latency on instance B
        b.dma_req = 1; b.dma_we = 0; b.dma_addr = 16'h00FF;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 0) check("t6_gnt", {b.dma_gnt, b.mem_rd}, 2'b11);
            check($sformatf("t6_busy_%0d", k), b.busy, (k >= 1 && k <= 4));
            check($sformatf("t6_rvalid_%0d", k), {b.dma_rvalid, b.cpu_rvalid}, {(k == 4), 1'b0});
            if (k == 4) check("t6_rdata", b.dma_rdata, 16'hA5A5);
            tick();
            if (k == 0) b.dma_req = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
